// File: rtl/program_loader.sv
// program_loader: receives a byte-serial program image, writes it into
// instruction memory word by word and then releases the core from reset.
//
// Stream: LEN_HI, LEN_LO (N words), N x 4 data bytes (big-endian),
// then one checksum byte equal to the XOR of all data bytes.
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1. in_ready depends only on the FSM state. The sender may hold
// in_valid low for any number of cycles between bytes.
//
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   in_valid, in_data    - byte stream input
//   in_ready             - loader can accept a byte
//   imem_we/addr/wdata   - instruction memory write port (one strobe per word)
//   core_reset           - reset to the core; low only while running
//   done                 - load completed, core running
//   error                - load failed (sticky until reset)
//   state_dbg            - current FSM state encoding
module program_loader #(
  parameter int ADDR_W     = 10,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA    = 3'd2,
    CSUM    = 3'd3,
    RELEASE = 3'd4,
    RUN     = 3'd5,
    ERR     = 3'd6
  } state_t;

  // Largest word count that fits the memory; 17 bits so 2**16 is representable.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
  localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);

  state_t              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         word_idx_q, word_idx_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         word_q, word_d;       // first three bytes of the word
  logic [7:0]          csum_q, csum_d;
  logic [15:0]         hold_q, hold_d;
  logic                in_ready_q, in_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_reset_q, core_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                xfer;
  logic [15:0]         len_new;

  assign xfer    = in_valid && in_ready_q;
  assign len_new = {len_q[15:8], in_data};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_idx_d   = word_idx_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    csum_d       = csum_q;
    hold_d       = hold_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      LEN_HI: begin
        if (xfer) begin
          len_d   = {in_data, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d      = len_new;
          word_idx_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
          if (len_new == 16'd0 || {1'b0, len_new} > MAX_WORDS) state_d = ERR;
          else                                                  state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          word_d     = {word_q[15:0], in_data};
          csum_d     = csum_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q[ADDR_W-1:0];
            imem_wdata_d = {word_q, in_data};
            word_idx_d   = word_idx_q + 16'd1;
            // Leave DATA on the same edge that raises the final write strobe.
            if (word_idx_q == len_q - 16'd1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          hold_d  = '0;
          state_d = (in_data == csum_q) ? RELEASE : ERR;
        end
      end
      RELEASE: begin
        if (hold_q == HOLD_LAST) state_d = RUN;
        else                     hold_d  = hold_q + 16'd1;
      end
      default: ;  // RUN and ERR are terminal until reset
    endcase

    // in_ready tracks the state being entered so it never accepts a byte
    // in a state that cannot consume it.
    in_ready_d   = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                   (state_d == DATA)   || (state_d == CSUM);
    // Status outputs follow the registered state one cycle later, so the
    // core sees reset drop RESET_HOLD+1 cycles after the checksum byte.
    core_reset_d = (state_q != RUN);
    done_d       = (state_q == RUN);
    error_d      = (state_q == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LEN_HI;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      hold_q       <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      hold_q       <= hold_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign state_dbg  = state_q;

endmodule
